// File: rtl/ritc_train_pkg.sv
// Shared types and constants for the RITC training-pattern monitor.
// Holds the FSM encoding, channel geometry and the nibble rotation helper.
package ritc_train_pkg;

  localparam int NUM_LINES = 12;
  localparam int DESER     = 4;
  localparam int NUM_CH    = 6;
  localparam int WORD_W    = NUM_LINES * DESER;

  localparam logic [DESER-1:0] DEF_PATTERN = 4'b1100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Rotate right by r bit positions within one nibble.
  function automatic logic [DESER-1:0] rot(
    input logic [DESER-1:0] p,
    input int unsigned      r
  );
    logic [2*DESER-1:0] d;
    d = {p, p} >> r;
    return d[DESER-1:0];
  endfunction

endpackage

// File: rtl/ritc_line_matcher.sv
// Combinational compare of one bit-line nibble against all four
// rotations of the training pattern, plus a nominal-alignment mismatch.
module ritc_line_matcher
  import ritc_train_pkg::*;
(
  input  logic [DESER-1:0] nibble_i,
  input  logic [DESER-1:0] pattern_i,
  output logic [DESER-1:0] rot_match_o,
  output logic             mismatch_o
);

  for (genvar r = 0; r < DESER; r++) begin : g_rot
    assign rot_match_o[r] = (nibble_i == rot(pattern_i, r));
  end

  assign mismatch_o = (nibble_i != pattern_i);

endmodule

// File: rtl/ritc_train_monitor.sv
// Training-pattern monitor: muxes one channel into a register, then
// accumulates per-line rotation matches and a saturating error count.
module ritc_train_monitor
  import ritc_train_pkg::*;
#(
  parameter logic [3:0] TRAIN_PATTERN = DEF_PATTERN,
  parameter int         WIN_BITS      = 16
) (
  input  logic                SYSCLK,
  input  logic                rst_i,
  input  logic [WORD_W-1:0]   CH0_IN,
  input  logic [WORD_W-1:0]   CH1_IN,
  input  logic [WORD_W-1:0]   CH2_IN,
  input  logic [WORD_W-1:0]   CH3_IN,
  input  logic [WORD_W-1:0]   CH4_IN,
  input  logic [WORD_W-1:0]   CH5_IN,
  input  logic [2:0]          ch_sel_i,
  input  logic [WIN_BITS-1:0] window_i,
  input  logic                start_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [WORD_W-1:0]   match_o,
  output logic [WIN_BITS-1:0] err_cnt_o
);

  state_e              state_q, state_d;
  logic [2:0]          sel_q, sel_d;
  logic [WIN_BITS-1:0] win_q, win_d;
  logic [WIN_BITS-1:0] cnt_q, cnt_d;
  logic [WIN_BITS-1:0] err_q, err_d;
  logic [WIN_BITS-1:0] eout_q, eout_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [WORD_W-1:0]   acc_q, acc_d;
  logic [WORD_W-1:0]   mout_q, mout_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [WORD_W-1:0]    ch_word;
  logic [WORD_W-1:0]    rot_m;
  logic [NUM_LINES-1:0] mis;
  logic                 any_mis;

  always_comb begin
    case (sel_q)
      3'd0:    ch_word = CH0_IN;
      3'd1:    ch_word = CH1_IN;
      3'd2:    ch_word = CH2_IN;
      3'd3:    ch_word = CH3_IN;
      3'd4:    ch_word = CH4_IN;
      default: ch_word = CH5_IN;
    endcase
  end

  for (genvar i = 0; i < NUM_LINES; i++) begin : g_line
    ritc_line_matcher u_match (
      .nibble_i    (word_q[DESER*i +: DESER]),
      .pattern_i   (TRAIN_PATTERN),
      .rot_match_o (rot_m[DESER*i +: DESER]),
      .mismatch_o  (mis[i])
    );
  end

  assign any_mis = |mis;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    eout_d  = eout_q;
    word_d  = word_q;
    acc_d   = acc_q;
    mout_d  = mout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          sel_d = ch_sel_i;
          win_d = window_i;
          if (window_i == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
            mout_d  = '1;
            eout_d  = '0;
          end else begin
            state_d = FILL;
            busy_d  = 1'b1;
          end
        end
      end
      FILL: begin
        word_d  = ch_word;
        acc_d   = '1;
        err_d   = '0;
        cnt_d   = win_q;
        state_d = RUN;
      end
      RUN: begin
        word_d = ch_word;
        acc_d  = acc_q & rot_m;
        if (any_mis && (err_q != '1)) begin
          err_d = err_q + WIN_BITS'(1);
        end
        cnt_d = cnt_q - WIN_BITS'(1);
        // Publish on the last word so done_o and results coincide.
        if (cnt_q == WIN_BITS'(1)) begin
          state_d = DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          mout_d  = acc_d;
          eout_d  = err_d;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge SYSCLK or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      sel_q   <= '0;
      win_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      eout_q  <= '0;
      word_q  <= '0;
      acc_q   <= '0;
      mout_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      eout_q  <= eout_d;
      word_q  <= word_d;
      acc_q   <= acc_d;
      mout_q  <= mout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign match_o   = mout_q;
  assign err_cnt_o = eout_q;

endmodule

// File: tb/tb_ritc_train_monitor.sv
// Directed bench for ritc_train_monitor: a 16-bit window instance
// and a 4-bit window instance for the saturation case.
module tb_ritc_train_monitor;

  logic        clk;
  logic        rst;
  logic [47:0] ch [6];

  logic        start;
  logic [2:0]  sel;
  logic [15:0] win;
  logic        busy, done;
  logic [47:0] match;
  logic [15:0] err;

  logic        s_start;
  logic [2:0]  s_sel;
  logic [3:0]  s_win;
  logic        s_busy, s_done;
  logic [47:0] s_match;
  logic [3:0]  s_err;

  int vectors;
  int miscompares;

  int done_at, ndone;
  bit busy1, busy_seen, busy_at_done;

  ritc_train_monitor #(.WIN_BITS(16)) u_dut (
    .SYSCLK    (clk),
    .rst_i     (rst),
    .CH0_IN    (ch[0]),
    .CH1_IN    (ch[1]),
    .CH2_IN    (ch[2]),
    .CH3_IN    (ch[3]),
    .CH4_IN    (ch[4]),
    .CH5_IN    (ch[5]),
    .ch_sel_i  (sel),
    .window_i  (win),
    .start_i   (start),
    .busy_o    (busy),
    .done_o    (done),
    .match_o   (match),
    .err_cnt_o (err)
  );

  ritc_train_monitor #(.WIN_BITS(4)) u_sat (
    .SYSCLK    (clk),
    .rst_i     (rst),
    .CH0_IN    (ch[0]),
    .CH1_IN    (ch[1]),
    .CH2_IN    (ch[2]),
    .CH3_IN    (ch[3]),
    .CH4_IN    (ch[4]),
    .CH5_IN    (ch[5]),
    .ch_sel_i  (s_sel),
    .window_i  (s_win),
    .start_i   (s_start),
    .busy_o    (s_busy),
    .done_o    (s_done),
    .match_o   (s_match),
    .err_cnt_o (s_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int mode, input int c);
    logic [47:0] g;
    case (mode)
      3: begin
        start = (c == 50);
        if (c >= 50) begin
          sel = 3'd0;
          win = 16'd3;
        end
      end
      4: ch[0] = (c == 7) ? 48'hCCCCCC3CCCCC : 48'hCCCCCCCCCCCC;
      6: begin
        g = {$urandom, $urandom};
        ch[3] = {g[47:4], 4'h0};
      end
      default: ;
    endcase
  endtask

  // Called #1 after a rising edge; that next edge samples start (cycle T).
  task automatic run(input bit sat, input logic [2:0] cs,
                     input logic [15:0] w, input int mode,
                     input int budget);
    int  c;
    logic b, d;
    done_at = -1;
    ndone = 0;
    busy1 = 0;
    busy_seen = 0;
    busy_at_done = 0;
    if (sat) begin
      s_sel = cs; s_win = w[3:0]; s_start = 1'b1;
    end else begin
      sel = cs; win = w; start = 1'b1;
    end
    @(posedge clk); #1;
    start = 1'b0;
    s_start = 1'b0;
    c = 1;
    drive(mode, c);
    while (c <= budget) begin
      @(negedge clk);
      b = sat ? s_busy : busy;
      d = sat ? s_done : done;
      if (c == 1) busy1 = b;
      if (b) busy_seen = 1;
      if (d) begin
        ndone++;
        if (done_at < 0) begin
          done_at = c;
          busy_at_done = b;
        end
      end
      if (done_at > 0 && c >= done_at + 3) break;
      @(posedge clk); #1;
      c++;
      drive(mode, c);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    start = 1'b0; sel = '0; win = '0;
    s_start = 1'b0; s_sel = '0; s_win = '0;
    ch[0] = 48'h0;
    ch[1] = 48'h0;
    ch[2] = 48'hCCCCCCCCCCCC;
    ch[3] = 48'h0;
    ch[4] = 48'h666666666666;
    ch[5] = 48'h333333333333;
    #3;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_match", 64'(match), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Nominal alignment on CH2.
    run(0, 3'd2, 16'd8, 0, 40);
    chk("ch2_done_at", 64'(done_at), 64'd10);
    chk("ch2_busy_t1", 64'(busy1), 64'd1);
    chk("ch2_busy_at_done", 64'(busy_at_done), 64'd0);
    chk("ch2_ndone", 64'(ndone), 64'd1);
    chk("ch2_match", 64'(match), 64'h111111111111);
    chk("ch2_err", 64'(err), 64'd0);

    // Async reset in the middle of a 10-word check.
    sel = 3'd2; win = 16'd10; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_busy_before", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    chk("mid_rst_match", 64'(match), 64'd0);
    chk("mid_rst_err", 64'(err), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run(0, 3'd2, 16'd4, 0, 30);
    chk("post_rst_done_at", 64'(done_at), 64'd6);
    chk("post_rst_match", 64'(match), 64'h111111111111);
    chk("post_rst_err", 64'(err), 64'd0);

    // Rotation 1 on CH4; start/sel/window poked mid-check.
    run(0, 3'd4, 16'd100, 3, 200);
    chk("ch4_done_at", 64'(done_at), 64'd102);
    chk("ch4_ndone", 64'(ndone), 64'd1);
    chk("ch4_match", 64'(match), 64'h222222222222);
    chk("ch4_err", 64'(err), 64'd100);
    chk("ch4_idle_after", 64'(busy), 64'd0);

    // One bad word on CH0 line 5.
    run(0, 3'd0, 16'd16, 4, 40);
    chk("ch0_done_at", 64'(done_at), 64'd18);
    chk("ch0_match", 64'(match), 64'h111111011111);
    chk("ch0_err", 64'(err), 64'd1);
    ch[0] = 48'h0;

    // Zero-length window.
    run(0, 3'd5, 16'd0, 0, 10);
    chk("w0_done_at", 64'(done_at), 64'd1);
    chk("w0_busy_seen", 64'(busy_seen), 64'd0);
    chk("w0_ndone", 64'(ndone), 64'd1);
    chk("w0_match", 64'(match), 64'hFFFFFFFFFFFF);
    chk("w0_err", 64'(err), 64'd0);

    // Sel 6 aliases CH5 (all 0011 = rotation 2).
    run(0, 3'd6, 16'd3, 0, 20);
    chk("sel6_match", 64'(match), 64'h444444444444);
    chk("sel6_err", 64'(err), 64'd3);

    // 4-bit window instance saturation.
    run(1, 3'd3, 16'd15, 5, 40);
    chk("sat_done_at", 64'(done_at), 64'd17);
    chk("sat_err", 64'(s_err), 64'd15);
    chk("sat_match", 64'(s_match), 64'h0);
    run(1, 3'd3, 16'hF, 6, 40);
    chk("sat2_err", 64'(s_err), 64'd15);
    chk("sat2_busy", 64'(s_busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ritc_train_monitor.md
# ritc_train_monitor

Training-pattern monitor that sits directly downstream of the RITC dual datapath. It consumes the six 48-bit deserialized channel words (12 bit-lines × 4 deserialized bits each) on SYSCLK. On command, it checks one selected channel over a programmable window and reports, per bit-line, which nibble rotations matched the training pattern on every cycle. It also counts cycles with any mismatch against the nominal alignment. Firmware uses the results to drive bitslip and IDELAY adjustment.

## Interface
Parameters:
- TRAIN_PATTERN, 4'b1100, expected 4-bit nibble per bit-line at rotation 0; all four rotations must be distinct.
- WIN_BITS, 16, width of window length and error counter.

Ports:
- SYSCLK  in  1  sole clock; all logic on its rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- CH0_IN … CH5_IN  in  48 each  deserialized channel words; bits [4i+3:4i] are bit-line i, i = 0..11.
- ch_sel_i  in  3  channel to monitor, 0–5; values 6 and 7 select CH5.
- window_i  in  WIN_BITS  number of data words to check.
- start_i  in  1  single-cycle start request.
- busy_o  out  1  high while a check is in progress.
- done_o  out  1  one-cycle pulse when results are updated.
- match_o  out  48  bit 4i+r set means line i equalled rot(TRAIN_PATTERN, r) on every checked word.
- err_cnt_o  out  WIN_BITS  count of checked words in which any line ≠ TRAIN_PATTERN; saturating.

## Operation
- rot(p, r) is p rotated right by r bit positions. With p = 1100: r=1 gives 0110, r=2 gives 0011, r=3 gives 1001.
- The FSM has four states: IDLE, FILL, RUN, DONE.
- IDLE: start_i=1 latches ch_sel_i and window_i, then goes to FILL. If the latched window is 0, go straight to DONE with match_o = all ones and err_cnt_o = 0.
- FILL: one cycle. The input mux register loads the selected channel word. The accumulators clear: the match accumulator to all ones, the error counter to 0, the word counter to the latched window. Next state is RUN.
- RUN: for each registered word:
  - each match accumulator bit ANDs with (line i == rot(pattern, r));
  - the error counter increments if any line ≠ pattern and it is below 2^WIN_BITS−1;
  - the word counter decrements.
  - When the word counter reaches 1 and is consumed, go to DONE.
- DONE: one cycle. Transfer the accumulators to match_o and err_cnt_o, pulse done_o, return to IDLE.
- start_i outside IDLE is ignored. It is not queued.
- Outputs hold their values between checks. Inputs change only at the next DONE.
- Reset, including mid-check, forces IDLE. Reset values: busy_o=0, done_o=0, match_o=0, err_cnt_o=0, all internal counters 0.

## Timing
- start_i sampled high in IDLE at cycle T:
  - busy_o rises at T+1;
  - words presented on the selected CHn_IN at cycles T+1 … T+N are checked;
  - done_o pulses at T+N+2;
  - busy_o falls in the same cycle as done_o.
- window_i = 0: done_o pulses at T+1 and busy_o stays low.
- The earliest accepted restart is the cycle after done_o (T+N+3).
- Latency from a word on the input to its effect on the accumulators is 2 cycles (mux register, then compare/accumulate).
- ch_sel_i and window_i changes after T do not affect the running check.
- The saturated counter reads 2^WIN_BITS−1 even if further errors occur.

## Structure
- Shared package (ritc_train_pkg) holds:
  - the state encoding (IDLE/FILL/RUN/DONE);
  - the default TRAIN_PATTERN;
  - line count (12), deserialization factor (4), channel count (6);
  - the rot() helper function.
- Sub-module ritc_line_matcher: one 4-bit nibble plus pattern in, 4 registered-free rotation-match flags and a mismatch flag out. Instantiate 12 times.
- The top level holds the channel mux register, FSM, counters and accumulators.

## Test plan
- Reset mid-RUN: assert rst_i at T+3 of a 10-word check. Required: all outputs 0 immediately; a new start then completes normally.
- CH2 driven with every nibble = 1100, ch_sel=2, window=8. Required: done_o at T+10; match_o = 48'h111111111111; err_cnt_o = 0.
- CH4 lines all 0110 (rotation 1), window=100. Required: match_o = 48'h222222222222; err_cnt_o = 100.
- CH0 line 5 = 0011 on one word only, others correct, window=16. Required: match_o nibble 5 = 0000, other nibbles = 0001; err_cnt_o = 1.
- window=0 at start. Required: done_o at T+1; match_o = all ones; err_cnt_o = 0; busy_o never high. start_i pulsed mid-check is ignored, with no extra done_o.
- WIN_BITS=4, constant mismatch, window=15, then a second check with window=0xF and garbage data. Required: err_cnt_o = 15 and saturates at 15 with no wrap.
